prt_dptx_enc8b10b: RTL

// - Per-lane 8b/10b encoder between the DP TX link layer and a transceiver with no hard 8b/10b encoder.
// - Consumes 11-bit link symbols {disp_ctl, disp_val, k, dat[7:0]} and emits 10-bit code groups for the PHY.
// - Tracks running disparity (RD) per lane across all P_SPL symbols of a clock and across clocks.
// - Honours forced-disparity requests from the link layer.

---
 rtl/prt_dptx_enc8b10b_if.sv | 29 ++
 rtl/prt_dptx_enc8b10b.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/prt_dptx_enc8b10b_if.sv
// Link-side bundle for the per-lane 8b/10b encoder: symbol input and code-group output.
interface prt_dptx_enc8b10b_if #(
    parameter int unsigned P_LANES = 4,
    parameter int unsigned P_SPL   = 2
);
    logic                        LNK_VLD_IN;
    logic [P_LANES*P_SPL*11-1:0] LNK_DAT_IN;
    logic                        LNK_VLD_OUT;
    logic [P_LANES*P_SPL*10-1:0] LNK_DAT_OUT;
    logic [P_LANES-1:0]          ERR_OUT;

    // Link layer side: drives symbols, observes code groups.
    modport master (
        output LNK_VLD_IN,
        output LNK_DAT_IN,
        input  LNK_VLD_OUT,
        input  LNK_DAT_OUT,
        input  ERR_OUT
    );

    // Encoder side.
    modport slave (
        input  LNK_VLD_IN,
        input  LNK_DAT_IN,
        output LNK_VLD_OUT,
        output LNK_DAT_OUT,
        output ERR_OUT
    );
endinterface

// File: rtl/prt_dptx_enc8b10b.sv
// Per-lane 8b/10b encoder for the DP TX path. Two-stage pipeline: stage 1 registers the link
// symbols, stage 2 encodes every lane's P_SPL symbols through a running-disparity chain and
// registers the code groups, valid and illegal-K flags.
module prt_dptx_enc8b10b #(
    parameter int unsigned P_LANES = 4,
    parameter int unsigned P_SPL   = 2
) (
    input logic                CLK_IN,
    input logic                RST_IN,
    prt_dptx_enc8b10b_if.slave lnk
);
    localparam int unsigned NSym = P_LANES * P_SPL;
    localparam int unsigned InW  = NSym * 11;
    localparam int unsigned OutW = NSym * 10;

    // 5b/6b primary (RD-) column, written abcdei with a in the MSB.
    function automatic logic [5:0] tbl_6b(input logic [4:0] x);
        logic [5:0] c;
        unique case (x)
            5'd0:  c = 6'b100111;
            5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;
            5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;
            5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;
            5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;
            5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;
            5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;
            5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;
            5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;
            5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;
            5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;
            5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;
            5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;
            5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;
            5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;
            5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b data column selected when the 6b sub-block leaves RD-, written fghj.
    function automatic logic [3:0] tbl_4b_d(input logic [2:0] y);
        logic [3:0] c;
        unique case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

    // 3b/4b control column selected when the 6b sub-block leaves RD-, written fghj.
    function automatic logic [3:0] tbl_4b_k(input logic [2:0] y);
        logic [3:0] c;
        unique case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b0110;
            3'd2:    c = 4'b1010;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b0101;
            3'd6:    c = 4'b1001;
            default: c = 4'b0111;
        endcase
        return c;
    endfunction

    // Encodes one symbol at running disparity rd. Result is {illegal_k, rd_after, code[9:0]}
    // with code[0] = a (first bit on the wire).
    function automatic logic [11:0] enc_sym(input logic [7:0] dat, input logic k, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       k_ok;
        logic       unb6;
        logic       unb4;
        logic       rd_mid;
        logic       use_a7;
        logic [5:0] c6;
        logic [3:0] c4;
        x    = dat[4:0];
        y    = dat[7:5];
        k_ok = k && ((x == 5'd28) ||
               ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30))));
        c6   = (k_ok && (x == 5'd28)) ? 6'b001111 : tbl_6b(x);
        unb6 = ($countones(c6) != 3);
        // D.7 is balanced but still has distinct RD- and RD+ forms.
        c6     = c6 ^ {6{rd && (unb6 || (x == 5'd7))}};
        rd_mid = rd ^ unb6;
        // Alternate D.x.7 avoids a run of five identical bits across the sub-block boundary.
        use_a7 = !k_ok && (y == 3'd7) &&
                 ((!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                  (rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        if (k_ok) begin
            c4 = tbl_4b_k(y);
        end else if (use_a7) begin
            c4 = 4'b0111;
        end else begin
            c4 = tbl_4b_d(y);
        end
        unb4 = ($countones(c4) != 2);
        // Control 4b codes and D.x.3 flip with disparity even when balanced.
        c4 = c4 ^ {4{rd_mid && (k_ok || unb4 || (y == 3'd3))}};
        return {k && !k_ok, rd_mid ^ unb4,
                c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
    endfunction

    logic                s1_vld_q;
    logic [InW-1:0]      s1_dat_q;
    logic                out_vld_q;
    logic [OutW-1:0]     out_dat_q;
    logic [OutW-1:0]     out_dat_d;
    logic [P_LANES-1:0]  err_q;
    logic [P_LANES-1:0]  err_d;
    logic [P_LANES-1:0]  rd_q;
    logic [P_LANES-1:0]  rd_d;

    logic                rd_c;
    logic                err_c;
    logic [10:0]         sym;
    logic [11:0]         res;

    // Per-lane disparity chain over the P_SPL symbols of the registered stage-1 word.
    always_comb begin
        out_dat_d = out_dat_q;
        err_d     = '0;
        rd_d      = rd_q;
        rd_c      = 1'b0;
        err_c     = 1'b0;
        sym       = '0;
        res       = '0;
        for (int unsigned l = 0; l < P_LANES; l++) begin
            rd_c  = rd_q[l];
            err_c = 1'b0;
            for (int unsigned j = 0; j < P_SPL; j++) begin
                sym = s1_dat_q[(l*P_SPL+j)*11 +: 11];
                // Forced disparity overrides the chain for this symbol and those after it.
                res = enc_sym(sym[7:0], sym[8], sym[10] ? sym[9] : rd_c);
                if (s1_vld_q) begin
                    out_dat_d[(l*P_SPL+j)*10 +: 10] = res[9:0];
                end
                err_c = err_c | res[11];
                rd_c  = res[10];
            end
            if (s1_vld_q) begin
                rd_d[l]  = rd_c;
                err_d[l] = err_c;
            end
        end
    end

    // Both pipeline stages and the lane RD registers; reset discards anything in flight.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            err_q     <= '0;
            rd_q      <= '0;
        end else begin
            s1_vld_q  <= lnk.LNK_VLD_IN;
            s1_dat_q  <= lnk.LNK_DAT_IN;
            out_vld_q <= s1_vld_q;
            out_dat_q <= out_dat_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
        end
    end

    assign lnk.LNK_VLD_OUT = out_vld_q;
    assign lnk.LNK_DAT_OUT = out_dat_q;
    assign lnk.ERR_OUT     = err_q;

endmodule
